// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle sequencer: state encoding, PC source
// and trap cause codes, and the legal RV32 major opcodes (also used by the decoder).
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'b00,
        PC_TARGET = 2'b01,
        PC_TRAP   = 2'b10
    } pc_src_e;

    typedef enum logic [1:0] {
        CAUSE_ILLEGAL = 2'd0,
        CAUSE_FETCH   = 2'd1,
        CAUSE_DATA    = 2'd2
    } trap_cause_e;

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_CUST0  = 7'b0001011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    // Wide enough for the largest supported timeout (255).
    localparam int TIMER_W = 8;

    function automatic logic is_legal_opcode(input logic [6:0] op);
        case (op)
            OP_REG, OP_LOAD, OP_IMM, OP_BRANCH, OP_STORE, OP_CUST0,
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_SYSTEM, OP_FENCE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive request cycles without ack; flags the TIMEOUT-th such cycle.
// Shared between the instruction and data ports, which are never active together.
module mem_wait_timer
    import ctrl_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic req_i,
    input  logic ack_i,
    output logic timeout_o
);

    logic [TIMER_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (req_i && !ack_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // An ack arriving on the final allowed cycle suppresses the timeout.
    assign timeout_o = req_i && !ack_i && (cnt_q == TIMER_W'(TIMEOUT - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with a TRAP path
// for illegal opcodes and memory timeouts, plus a retired-instruction counter.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             w_en,
    input  logic             mw_en,
    input  logic             maddr_sel,
    input  logic             jump_en,
    input  logic             branch_taken,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    output logic             imem_req,
    output logic             ir_we,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             rf_we,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             trap_valid,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instret,
    output logic [2:0]       state_dbg
);

    state_e             state_q, state_d;
    logic [1:0]         trap_cause_q, trap_cause_d;
    logic [CNT_W-1:0]   instret_q, instret_d;
    logic               timer_req, timer_ack, timer_clear, timeout;

    // Timer request is derived from state alone to keep it off the FSM's combinational path.
    assign timer_req   = !rst && (state_q == ST_FETCH || state_q == ST_MEM);
    assign timer_ack   = (state_q == ST_FETCH) ? imem_ack : dmem_ack;
    assign timer_clear = rst || (state_d != state_q);

    mem_wait_timer #(.TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (timer_clear),
        .req_i     (timer_req),
        .ack_i     (timer_ack),
        .timeout_o (timeout)
    );

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        state_d      = state_q;
        trap_cause_d = trap_cause_q;
        instret_d    = instret_q;
        imem_req     = 1'b0;
        ir_we        = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        rf_we        = 1'b0;
        pc_we        = 1'b0;
        pc_src       = PC_SEQ;
        trap_valid   = 1'b0;

        if (rst) begin
            state_d = ST_FETCH;
        end else begin
            unique case (state_q)
                ST_FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ack) begin
                        ir_we   = 1'b1;
                        state_d = ST_DECODE;
                    end else if (timeout) begin
                        trap_cause_d = CAUSE_FETCH;
                        state_d      = ST_TRAP;
                    end
                end
                ST_DECODE: begin
                    if (is_legal_opcode(opcode)) begin
                        state_d = ST_EXEC;
                    end else begin
                        trap_cause_d = CAUSE_ILLEGAL;
                        state_d      = ST_TRAP;
                    end
                end
                ST_EXEC: begin
                    state_d = (maddr_sel || mw_en) ? ST_MEM : ST_WB;
                end
                ST_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = mw_en;
                    if (dmem_ack) begin
                        state_d = ST_WB;
                    end else if (timeout) begin
                        trap_cause_d = CAUSE_DATA;
                        state_d      = ST_TRAP;
                    end
                end
                ST_WB: begin
                    rf_we     = w_en;
                    pc_we     = 1'b1;
                    pc_src    = (jump_en || branch_taken) ? PC_TARGET : PC_SEQ;
                    instret_d = instret_q + 1'b1;
                    state_d   = ST_FETCH;
                end
                ST_TRAP: begin
                    pc_we      = 1'b1;
                    pc_src     = PC_TRAP;
                    trap_valid = 1'b1;
                    state_d    = ST_FETCH;
                end
                default: state_d = ST_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_FETCH;
            trap_cause_q <= CAUSE_ILLEGAL;
            instret_q    <= '0;
        end else begin
            state_q      <= state_d;
            trap_cause_q <= trap_cause_d;
            instret_q    <= instret_d;
        end
    end

    assign trap_cause = trap_cause_q;
    assign instret    = instret_q;
    assign state_dbg  = state_q;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle sequencer for the RV32 core. It steps each instruction through FETCH, DECODE, EXEC, optional MEM and WB. It drives the instruction and data memory handshakes, the IR latch, the PC update and register-file write gating, using the decoder's per-opcode control outputs. Illegal opcodes and memory timeouts redirect the PC to the trap vector, and the block keeps a retired-instruction counter.

Parameters:
MEM_TIMEOUT, 15, maximum consecutive request cycles without ack before a fault (legal range 1..255)
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  input  1  core clock
rst  input  1  reset; one clock, synchronous, active-high
opcode  input  7  inst[6:0] from the IR
w_en  input  1  decoder register-write enable
mw_en  input  1  decoder store indicator
maddr_sel  input  1  decoder load indicator
jump_en  input  1  decoder unconditional jump
branch_taken  input  1  branch-compare result, valid in EXEC/WB
imem_ack  input  1  instruction memory data valid
dmem_ack  input  1  data memory access complete
imem_req  output  1  instruction fetch request
ir_we  output  1  latch fetched word into IR
dmem_req  output  1  data access request
dmem_we  output  1  data access is a write
rf_we  output  1  gated register-file write
pc_we  output  1  PC update strobe
pc_src  output  2  00 = pc+4, 01 = branch/jump target, 10 = trap vector
trap_valid  output  1  one-cycle trap pulse
trap_cause  output  2  0 = illegal opcode, 1 = fetch fault, 2 = data fault
instret  output  CNT_W  retired-instruction count
state_dbg  output  3  current state encoding

Behaviour:
- Reset:
  - state = FETCH; instret = 0; wait counter = 0; trap_cause = 0.
  - All strobes are 0 during the rst cycle.
  - imem_req asserts in the first cycle after rst deasserts.
- FETCH:
  - imem_req = 1, held until imem_ack.
  - On ack: ir_we = 1 in the same cycle (Mealy), then go to DECODE.
- DECODE:
  - One cycle.
  - Legal opcodes: 0110011, 0000011, 0010011, 1100011, 0100011, 0001011, 0110111, 0010111, 1101111, 1100111, 1110011, 0001111.
  - Illegal -> TRAP with cause 0. Legal -> EXEC.
- EXEC:
  - One cycle.
  - maddr_sel | mw_en -> MEM; otherwise -> WB.
- MEM:
  - dmem_req = 1 and dmem_we = mw_en, held until dmem_ack.
  - On ack -> WB.
- WB (one cycle):
  - rf_we = w_en; pc_we = 1.
  - pc_src = 01 if jump_en | branch_taken, else 00.
  - instret += 1, wrapping modulo 2^CNT_W.
  - -> FETCH.
- TRAP (one cycle):
  - pc_we = 1; pc_src = 10; trap_valid = 1; rf_we = 0.
  - trap_cause is registered on TRAP entry and held until the next TRAP.
  - instret unchanged. -> FETCH.
- Wait counter:
  - Cleared on entry to FETCH/MEM; increments each request cycle without ack.
  - If ack has not arrived by the MEM_TIMEOUT-th request cycle, go to TRAP (cause 1 from FETCH, cause 2 from MEM).
  - The request is therefore high for at most MEM_TIMEOUT cycles.
  - Ack in the same cycle as timeout: ack wins, no trap.
- Strobe rules:
  - Requests and strobes are deasserted in every state other than the one that owns them.
  - rf_we is never 1 outside WB. pc_we is never 1 outside WB/TRAP.
- FENCE/ECALL opcodes are legal. They complete through WB per the decoder's w_en/jump_en.
- rst mid-operation (any state, including MEM with req high): all requests drop at the next edge; state = FETCH; counters cleared.
- Latency with zero-wait memory: non-memory instruction = 4 cycles; load/store = 5 cycles.

Decomposition:
- Package ctrl_pkg:
  - state encodings: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, TRAP = 5
  - pc_src codes
  - trap cause codes
  - legal opcode constants, shared with the decoder
- Sub-module mem_wait_timer:
  - wait counter plus timeout compare
  - inputs: clear, req, ack; output: timeout
  - one instance, reused for imem and dmem since they are never active together

Test Plan:
- ADD (opcode 0110011), imem_ack same cycle as req, w_en = 1 -> states 0, 1, 2, 4; rf_we = 1 and pc_src = 00 in cycle 4; instret 0 -> 1.
- LW, dmem_ack after 3 wait cycles -> dmem_req high 4 cycles, dmem_we = 0; WB follows next cycle; load total 8 cycles.
- SW with dmem_ack never asserted, MEM_TIMEOUT = 15 -> dmem_req high exactly 15 cycles; TRAP with trap_cause = 2, pc_src = 10; instret unchanged.
- Opcode 1111111 -> TRAP directly after DECODE; trap_valid pulses 1 cycle; cause = 0; next cycle imem_req = 1.
- BEQ with branch_taken = 1 -> WB has pc_src = 01, rf_we = 0.
- Second case: w_en = 1 and imem_ack arriving on the 15th request cycle -> no trap, normal completion.
- rst asserted during MEM with dmem_req high -> next cycle dmem_req = 0, state_dbg = 0, instret = 0; fetch resumes after rst release.
